// File: rtl/heartbeat_scan_ctrl.sv
// Round-robin scheduler time-sharing one heartbeat counter across sensors.
// Optional build macro HB_SCAN_AVG_EN: per-channel two-sample averaging.
module heartbeat_scan_ctrl #(
  parameter int          NUM_CH         = 4,
  parameter int          SETTLE_CYCLES  = 4,
  parameter int          TIMEOUT_CYCLES = 1100,
  parameter logic [7:0]  BPM_LO         = 8'd50,
  parameter logic [7:0]  BPM_HI         = 8'd150
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic [NUM_CH-1:0] pulse_in,
  output logic              dp_pulse,
  output logic              dp_reset,
  input  logic [7:0]        dp_bpm,
  input  logic              dp_new_bpm,
  output logic [2:0]        ch_sel,
  output logic [7:0]        bpm_out,
  output logic [2:0]        bpm_ch,
  output logic              bpm_valid,
  output logic              timeout,
  output logic [NUM_CH-1:0] alarm,
  input  logic [NUM_CH-1:0] alarm_clr,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_STORE,
    S_NEXT
  } state_t;

  localparam int CMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                        TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ONE     = {{(NUM_CH-1){1'b0}}, 1'b1};

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              meas_done;
  logic [7:0]        raw;
  logic [7:0]        res;
  logic              hit;
  logic [NUM_CH-1:0] set_vec;

  // First set mask bit at or after start, wrapping around the channel count.
  function automatic logic [2:0] pick(
    input logic [NUM_CH-1:0] m,
    input int                start
  );
    logic [2:0]        r;
    logic              found;
    logic [NUM_CH-1:0] sh;
    int                k;
    r     = 3'(start % NUM_CH);
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      k  = (start + i) % NUM_CH;
      sh = m >> k;
      if (!found && sh[0]) begin
        r     = 3'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    dp_pulse = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state == S_MEASURE && ch_sel == 3'(i)) begin
        dp_pulse = pulse_in[i];
      end
    end
  end

`ifdef HB_SCAN_AVG_EN
  logic [7:0]        hist [NUM_CH];
  logic [NUM_CH-1:0] hvalid;
  logic [7:0]        h_prev;
  logic              h_ok;
  logic [8:0]        sum;

  always_comb begin
    h_prev = 8'd0;
    h_ok   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) begin
        h_prev = hist[i];
        h_ok   = hvalid[i];
      end
    end
  end
`endif

  always_comb begin
    meas_done = (state == S_MEASURE) &&
                (dp_new_bpm || cnt == TO_LAST);
    raw = dp_new_bpm ? dp_bpm : 8'd0;
`ifdef HB_SCAN_AVG_EN
    sum = {1'b0, h_prev} + {1'b0, raw};
    res = (dp_new_bpm && h_ok) ? sum[8:1] : raw;
`else
    res = raw;
`endif
    hit = !dp_new_bpm || res < BPM_LO || res > BPM_HI;
    set_vec = (meas_done && hit) ? (ONE << ch_sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch_sel    <= 3'd0;
      bpm_out   <= 8'd0;
      bpm_ch    <= 3'd0;
      bpm_valid <= 1'b0;
      timeout   <= 1'b0;
      alarm     <= '0;
      busy      <= 1'b0;
      dp_reset  <= 1'b1;
    end else begin
      bpm_valid <= 1'b0;
      timeout   <= 1'b0;
      alarm     <= (alarm & ~alarm_clr) | set_vec;
      unique case (state)
        S_IDLE: begin
          if (enable && |chan_mask) begin
            state    <= S_SETTLE;
            ch_sel   <= pick(chan_mask, int'(ch_sel));
            cnt      <= '0;
            busy     <= 1'b1;
            dp_reset <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state    <= S_MEASURE;
            cnt      <= '0;
            dp_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          // A strobe on the last allowed cycle beats the timeout.
          if (meas_done) begin
            state     <= S_STORE;
            bpm_out   <= res;
            bpm_ch    <= ch_sel;
            bpm_valid <= 1'b1;
            timeout   <= !dp_new_bpm;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STORE: begin
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (|chan_mask) begin
            ch_sel <= pick(chan_mask, int'(ch_sel) + 1);
          end
          if (enable && |chan_mask) begin
            state    <= S_SETTLE;
            cnt      <= '0;
            dp_reset <= 1'b1;
          end else begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            dp_reset <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          dp_reset <= 1'b1;
        end
      endcase
    end
  end

`ifdef HB_SCAN_AVG_EN
  // History keeps the published value; a timeout invalidates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hvalid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hist[i] <= 8'd0;
      end
    end else if (meas_done) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == 3'(i)) begin
          hist[i]   <= res;
          hvalid[i] <= dp_new_bpm;
        end
      end
    end
  end
`endif

endmodule
